emulate_pull_sampler: RTL



---
 rtl/emulate_pull_pkg.sv | 15 +
 rtl/pull_debounce_bit.sv | 50 +++++
 rtl/emulate_pull_sampler.sv | 84 ++++++++
 3 files changed

// File: rtl/emulate_pull_pkg.sv
// Shared types and helpers for the pull-emulating pin sampler.
package emulate_pull_pkg;

    typedef enum logic [1:0] {
        PHASE_PULL,
        PHASE_SETTLE,
        PHASE_SAMPLE
    } phase_e;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/pull_debounce_bit.sv
// One pin's debouncer: flips its level after DEBOUNCE consecutive disagreeing
// samples and reports the change as one-cycle rise/fall strobes.
module pull_debounce_bit
    import emulate_pull_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic sample_en,
    input  logic clear,
    input  logic reset_level,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int DW = cnt_width(DEBOUNCE + 1);
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE - 1);

    logic [DW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            level <= reset_level;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (sample_en) begin
                if (sample == level) begin
                    count <= '0;
                end else if (count == LAST) begin
                    level <= ~level;
                    rise  <= ~level;
                    fall  <= level;
                    count <= '0;
                end else begin
                    count <= count + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/emulate_pull_sampler.sv
// Emulates pull resistors on bare pins: precharge each pin to its pull level,
// release, sample through a synchroniser, then debounce per bit.
module emulate_pull_sampler
    import emulate_pull_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int PERIOD = 16,
    parameter int PULL_CYCLES = 3,
    parameter logic [WIDTH-1:0] PULL_UP_MASK = {WIDTH{1'b0}},
    parameter int DEBOUNCE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    inout  wire  [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             sample_stb
);

    localparam int CW = cnt_width(PERIOD);
    localparam logic [CW-1:0] PULL_END = CW'(PULL_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0]    cnt;
    logic             en_q;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    phase_e           phase;
    logic             drive;
    logic             sample_en;

    always_comb begin
        phase = PHASE_SETTLE;
        if (cnt < PULL_END) begin
            phase = PHASE_PULL;
        end else if (cnt == LAST) begin
            phase = PHASE_SAMPLE;
        end
        drive     = en_q && (phase == PHASE_PULL);
        sample_en = en_q && (phase == PHASE_SAMPLE);
    end

    // Counter parks at zero while disabled so re-enabling always starts with a precharge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            en_q       <= 1'b0;
            sync1      <= PULL_UP_MASK;
            sync2      <= PULL_UP_MASK;
            sample_stb <= 1'b0;
        end else begin
            en_q       <= en;
            sync1      <= in;
            sync2      <= sync1;
            sample_stb <= sample_en;
            if (!en_q || phase == PHASE_SAMPLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign in[i] = drive ? PULL_UP_MASK[i] : 1'bz;

        pull_debounce_bit #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .sample     (sync2[i]),
            .sample_en  (sample_en),
            .clear      (~en_q),
            .reset_level(PULL_UP_MASK[i]),
            .level      (out[i]),
            .rise       (rise[i]),
            .fall       (fall[i])
        );
    end

endmodule
